// File: rtl/bist_controller_if.sv
// bist_controller_if: test-mode control and LFSR/CUT signals of the BIST sequencer.
// BIST_LOOP_EN adds the Run_Cnt run counter to the bundle.
interface bist_controller_if #(
   parameter int RESP_W = 4
);
   logic              Start;
   logic              Abort;
   logic [RESP_W-1:0] Resp;
   logic              Lfsr_Rst;
   logic              Lfsr_Seed;
   logic              Busy;
   logic              Done;
   logic              Pass;
   logic [RESP_W-1:0] Signature;
`ifdef BIST_LOOP_EN
   logic [7:0]        Run_Cnt;

   modport master (
      input  Start, Abort, Resp,
      output Lfsr_Rst, Lfsr_Seed, Busy, Done, Pass, Signature, Run_Cnt
   );
   modport slave (
      output Start, Abort, Resp,
      input  Lfsr_Rst, Lfsr_Seed, Busy, Done, Pass, Signature, Run_Cnt
   );
`else
   modport master (
      input  Start, Abort, Resp,
      output Lfsr_Rst, Lfsr_Seed, Busy, Done, Pass, Signature
   );
   modport slave (
      output Start, Abort, Resp,
      input  Lfsr_Rst, Lfsr_Seed, Busy, Done, Pass, Signature
   );
`endif
endinterface

// File: rtl/bist_controller.sv
// bist_controller: logic BIST sequencer with MISR compaction and signature compare.
// Define BIST_LOOP_EN for back-to-back runs, Run_Cnt and sticky-fail Pass.
module bist_controller #(
   parameter int              N_PAT   = 16,
   parameter int              N_PHASE = 2,
   parameter int              RESP_W  = 4,
   parameter logic [RESP_W-1:0] POLY   = RESP_W'(3),
   parameter logic [RESP_W-1:0] GOLDEN = '0
) (
   input logic               CLK,
   input logic               RST,
   bist_controller_if.master bus
);

   localparam int PAT_W = (N_PAT > 1) ? $clog2(N_PAT) : 1;
   localparam int PH_W  = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;

   typedef enum logic [2:0] {
      IDLE, INIT, RUN, RESEED, COMPARE, DONE
   } state_t;

   state_t            state;
   state_t            nxt;
   logic [PAT_W-1:0]  pat;
   logic [PH_W-1:0]   phase;
   logic [RESP_W-1:0] misr;
   logic [RESP_W-1:0] misr_nxt;
   logic              pass_q;
   logic              pat_last;
   logic              ph_last;
   logic              active;
   logic              abort_ok;
   logic              lrst;
   logic              seed;
   logic              busy;
   logic              done;

   assign pat_last = (pat == PAT_W'(N_PAT - 1));
   assign ph_last  = (phase == PH_W'(N_PHASE - 1));
   assign active   = (state == INIT) || (state == RUN) ||
                     (state == RESEED) || (state == COMPARE);
   assign abort_ok = bus.Abort && active;

   assign misr_nxt = {misr[RESP_W-2:0], 1'b0}
                   ^ (misr[RESP_W-1] ? POLY : '0)
                   ^ bus.Resp;

   always_ff @(posedge CLK) begin
      if (!RST) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (bus.Start) nxt = INIT;
         INIT:    nxt = RUN;
         RUN:     if (pat_last) nxt = ph_last ? COMPARE : RESEED;
         RESEED:  nxt = RUN;
         COMPARE: nxt = DONE;
`ifdef BIST_LOOP_EN
         DONE:    nxt = bus.Start ? INIT : IDLE;
`else
         DONE:    if (!bus.Start) nxt = IDLE;
`endif
         default: nxt = IDLE;
      endcase
      if (abort_ok) nxt = IDLE;
   end

   // RESEED announces the mode of the phase it is about to enter
   always_comb begin
      lrst = 1'b0;
      seed = 1'b1;
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         IDLE:    lrst = 1'b1;
         INIT:    begin lrst = 1'b1; busy = 1'b1; end
         RUN:     begin busy = 1'b1; seed = ~phase[0]; end
         RESEED:  begin busy = 1'b1; seed = phase[0]; end
         COMPARE: busy = 1'b1;
         DONE:    begin lrst = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

`ifdef BIST_LOOP_EN
   logic [7:0] run_cnt;
   logic       fresh;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         run_cnt <= '0;
         fresh   <= 1'b0;
      end else if (state == IDLE && bus.Start) begin
         fresh <= 1'b1;
      end else if (state == COMPARE && !abort_ok) begin
         fresh <= 1'b0;
         if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
      end
   end

   assign bus.Run_Cnt = run_cnt;
`endif

   always_ff @(posedge CLK) begin
      if (!RST) begin
         pat    <= '0;
         phase  <= '0;
         misr   <= '0;
         pass_q <= 1'b0;
      end else if (abort_ok) begin
         pass_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE:    if (bus.Start) pass_q <= 1'b0;
            INIT:    begin
               misr  <= '0;
               pat   <= '0;
               phase <= '0;
            end
            RUN:     begin
               misr <= misr_nxt;
               pat  <= pat + 1'b1;
            end
            RESEED:  begin
               pat   <= '0;
               phase <= phase + 1'b1;
            end
`ifdef BIST_LOOP_EN
            COMPARE: pass_q <= (misr == GOLDEN) && (fresh || pass_q);
`else
            COMPARE: pass_q <= (misr == GOLDEN);
`endif
            default: ;
         endcase
      end
   end

   assign bus.Lfsr_Rst  = lrst;
   assign bus.Lfsr_Seed = seed;
   assign bus.Busy      = busy;
   assign bus.Done      = done;
   assign bus.Pass      = pass_q;
   assign bus.Signature = misr;

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: directed stimulus with a run-timeline model of the sequencer.
// Build with BIST_LOOP_EN defined to also cover continuous runs.
module tb_bist_controller;

   localparam int         N_PAT   = 4;
   localparam int         N_PHASE = 2;
   localparam int         RESP_W  = 4;
   localparam logic [3:0] POLY    = 4'h3;
   localparam logic [3:0] GOLDEN  = 4'h0;
   localparam int         CMP_T   = N_PHASE * (N_PAT + 1);

   localparam int K_IDLE = 0;
   localparam int K_INIT = 1;
   localparam int K_RUN  = 2;
   localparam int K_RSD  = 3;
   localparam int K_CMP  = 4;
   localparam int K_DONE = 5;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   bit   chk_en = 1'b0;
   int   nvec = 0;
   int   nfail = 0;

   always #5 CLK = ~CLK;

   bist_controller_if #(.RESP_W(RESP_W)) bus ();

   bist_controller #(
      .N_PAT(N_PAT), .N_PHASE(N_PHASE), .RESP_W(RESP_W),
      .POLY(POLY), .GOLDEN(GOLDEN)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // run timeline: t=0 INIT, then N_PAT RUN + RESEED per phase, COMPARE at CMP_T
   function automatic int kind_of(input int t, input bit dn);
      if (dn) return K_DONE;
      if (t < 0) return K_IDLE;
      if (t == 0) return K_INIT;
      if (t == CMP_T) return K_CMP;
      return ((t - 1) % (N_PAT + 1) < N_PAT) ? K_RUN : K_RSD;
   endfunction

   function automatic logic [3:0] misr_step(input logic [3:0] s,
                                            input logic [3:0] r);
      logic [3:0] n;
      n = (s << 1) ^ (s[3] ? POLY : 4'h0);
      return n ^ r;
   endfunction

   int         m_t = -1;
   bit         m_done = 1'b0;
   logic [3:0] m_sig = 4'h0;
   bit         m_pass = 1'b0;
   bit         m_fresh = 1'b0;
   int         m_cnt = 0;
   int         m_k;
   int         m_ph;

   always_comb m_k = kind_of(m_t, m_done);
   always_comb m_ph = (m_t > 0) ? (m_t - 1) / (N_PAT + 1) : 0;

   always @(posedge CLK) begin
      if (!RST) begin
         m_t <= -1; m_done <= 1'b0; m_sig <= 4'h0;
         m_pass <= 1'b0; m_cnt <= 0; m_fresh <= 1'b0;
      end else if (m_k == K_IDLE) begin
         if (bus.Start) begin
            m_t <= 0; m_pass <= 1'b0; m_fresh <= 1'b1;
         end
      end else if (m_k == K_DONE) begin
`ifdef BIST_LOOP_EN
         m_done <= 1'b0;
         if (bus.Start) m_t <= 0;
`else
         if (!bus.Start) m_done <= 1'b0;
`endif
      end else if (bus.Abort) begin
         m_t <= -1; m_pass <= 1'b0;
      end else begin
         m_t <= m_t + 1;
         if (m_k == K_INIT) m_sig <= 4'h0;
         if (m_k == K_RUN) m_sig <= misr_step(m_sig, bus.Resp);
         if (m_k == K_CMP) begin
            m_t <= -1;
            m_done <= 1'b1;
            m_fresh <= 1'b0;
`ifdef BIST_LOOP_EN
            m_pass <= (m_sig == GOLDEN) && (m_fresh || m_pass);
`else
            m_pass <= (m_sig == GOLDEN);
`endif
            if (m_cnt < 255) m_cnt <= m_cnt + 1;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("busy", bus.Busy, (m_k >= K_INIT && m_k <= K_CMP));
         check("done", bus.Done, m_done);
         check("pass", bus.Pass, m_pass);
         check("sig", bus.Signature, m_sig);
         if (m_k != K_CMP)
            check("lrst", bus.Lfsr_Rst,
                  (m_k == K_IDLE || m_k == K_INIT || m_k == K_DONE));
         if (m_k == K_IDLE) check("seed_idle", bus.Lfsr_Seed, 1);
         if (m_k == K_RUN) check("seed_run", bus.Lfsr_Seed, (m_ph % 2 == 0));
         if (m_k == K_RSD) check("seed_rsd", bus.Lfsr_Seed, (m_ph % 2 == 1));
`ifdef BIST_LOOP_EN
         check("run_cnt", bus.Run_Cnt, m_cnt);
`endif
      end
   end

   task automatic wait_done(output int n);
      n = 0;
      while (n < 60) begin
         @(negedge CLK);
         n++;
         if (bus.Done) break;
      end
      if (n >= 60) check("done_timeout", bus.Done, 1);
   endtask

   int n;

   initial begin
      bus.Start = 1'b0;
      bus.Abort = 1'b0;
      bus.Resp  = 4'h0;
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      chk_en = 1'b1;
      @(negedge CLK);
      check("rst_lrst", bus.Lfsr_Rst, 1);
      check("rst_busy", bus.Busy, 0);
      check("rst_done", bus.Done, 0);
      check("rst_pass", bus.Pass, 0);
      check("rst_sig", bus.Signature, 4'h0);
      RST = 1'b1;

      // zero responses match GOLDEN=0
      bus.Start = 1'b1;
      wait_done(n);
      check("lat_run1", n, 12);
      check("pass_run1", bus.Pass, 1);
`ifndef BIST_LOOP_EN
      repeat (2) @(negedge CLK);
      check("done_hold", bus.Done, 1);
`endif
      bus.Start = 1'b0;
      repeat (2) @(negedge CLK);
      check("done_clr", bus.Done, 0);

      // Resp=1 each RUN cycle folds to 4'hD
      bus.Resp = 4'h1;
      bus.Start = 1'b1;
      wait_done(n);
      check("lat_run2", n, 12);
      check("sig_run2", bus.Signature, 4'hD);
      check("pass_run2", bus.Pass, 0);
      bus.Start = 1'b0;
      @(negedge CLK);

      // abort in first RUN cycle of phase 1; signature F is held
      bus.Start = 1'b1;
      repeat (7) @(negedge CLK);
      check("ab_busy_pre", bus.Busy, 1);
      check("ab_seed_pre", bus.Lfsr_Seed, 0);
      bus.Abort = 1'b1;
      bus.Start = 1'b0;
      @(negedge CLK);
      bus.Abort = 1'b0;
      check("ab_busy", bus.Busy, 0);
      check("ab_done", bus.Done, 0);
      check("ab_pass", bus.Pass, 0);
      check("ab_lrst", bus.Lfsr_Rst, 1);
      check("ab_sig", bus.Signature, 4'hF);

      // abort is ignored in IDLE
      bus.Abort = 1'b1;
      @(negedge CLK);
      bus.Abort = 1'b0;

      // reset in the middle of phase 0
      bus.Start = 1'b1;
      repeat (4) @(negedge CLK);
      check("mr_sig_pre", bus.Signature, 4'h3);
      RST = 1'b0;
      @(negedge CLK);
      check("mr_busy", bus.Busy, 0);
      check("mr_sig", bus.Signature, 4'h0);
      check("mr_lrst", bus.Lfsr_Rst, 1);
      check("mr_seed", bus.Lfsr_Seed, 1);
      RST = 1'b1;
      bus.Resp = 4'h0;
      wait_done(n);
      check("lat_restart", n, 12);
      check("pass_restart", bus.Pass, 1);
      bus.Start = 1'b0;
      @(negedge CLK);

`ifdef BIST_LOOP_EN
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      bus.Start = 1'b1;
      wait_done(n);
      check("loop_pass1", bus.Pass, 1);
      bus.Resp = 4'h1;
      wait_done(n);
      check("loop_lat2", n, 12);
      bus.Resp = 4'h0;
      wait_done(n);
      check("loop_cnt", bus.Run_Cnt, 3);
      check("loop_pass", bus.Pass, 0);
      bus.Start = 1'b0;
      repeat (2) @(negedge CLK);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
